// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 classic initiator: one valid/ready command becomes one
// bus cycle, answered on a valid/ready response port, with a no-ack timeout abort.
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic              expire;
    logic              cyc_nxt, stb_nxt, we_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [31:0]       adr_nxt, dat_nxt, rsp_rdata_nxt;
    logic [3:0]        sel_nxt;

    assign cmd_ready = (state == IDLE) && !rst;

    // cnt_inc is the number of stb cycles completed at the coming edge
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIM);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cyc_nxt       = wbm_cyc_o;
        stb_nxt       = wbm_stb_o;
        we_nxt        = wbm_we_o;
        adr_nxt       = wbm_adr_o;
        dat_nxt       = wbm_dat_o;
        sel_nxt       = wbm_sel_o;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (cmd_valid && cmd_ready) begin
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    we_nxt    = cmd_we;
                    adr_nxt   = cmd_addr;
                    dat_nxt   = cmd_wdata;
                    sel_nxt   = cmd_sel;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                cnt_nxt = cnt_inc;
                // ack takes priority over a timeout landing on the same edge
                if (wbm_ack_i || expire) begin
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    we_nxt        = 1'b0;
                    adr_nxt       = '0;
                    dat_nxt       = '0;
                    sel_nxt       = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = !wbm_ack_i;
                    rsp_rdata_nxt = (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'h0;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wbm_cyc_o <= cyc_nxt;
            wbm_stb_o <= stb_nxt;
            wbm_we_o  <= we_nxt;
            wbm_adr_o <= adr_nxt;
            wbm_dat_o <= dat_nxt;
            wbm_sel_o <= sel_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: expected responses are queued when a command is
// issued and compared when the response port presents them.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wb_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Waits for cmd_ready at a falling edge, presents the command, and returns just after
    // the accepting edge with the command fields scrambled.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        cmd_sel   = ~sel;
    endtask

    // Slave model: acks at the end of stb cycle number ack_at (0 = never).
    task automatic run_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                           input int exp_stb);
        int  n       = 0;
        int  stb_cnt = 0;
        bit  done    = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (wbm_stb_o) begin
                stb_cnt++;
                check("bus_cyc", wbm_cyc_o, 1);
                check("bus_adr", wbm_adr_o, addr);
                check("bus_dat", wbm_dat_o, wdata);
                check("bus_sel", wbm_sel_o, sel);
                check("bus_we", wbm_we_o, we);
                if (stb_cnt == ack_at) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = rdat;
                end
                @(posedge clk);
                #1;
                wbm_ack_i = 1'b0;
                wbm_dat_i = 32'hDEAD_BEEF;
            end else begin
                done = 1;
                check("end_cyc", wbm_cyc_o, 0);
                check("end_adr", wbm_adr_o, 0);
                check("end_dat", wbm_dat_o, 0);
                check("end_sel", wbm_sel_o, 0);
                check("end_we", wbm_we_o, 0);
                check("rsp_latency", rsp_valid, 1);
            end
        end
        check("stb_cycles", stb_cnt, exp_stb);
    endtask

    // Holds rsp_ready low for `hold` cycles (optionally with a stray ack and a
    // stray command), then completes the handshake.
    task automatic take_rsp(input int hold, input bit stray);
        rsp_t e;
        int   n = 0;
        e = '0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid", rsp_valid, 1);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) e = sb.pop_front();
        check("rsp_err", rsp_err, e.err);
        check("rsp_rdata", rsp_rdata, e.rdata);
        for (int i = 0; i < hold; i++) begin
            if (stray) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h5A5A_5A5A;
                cmd_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            wbm_ack_i = 1'b0;
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_err", rsp_err, e.err);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_cyc", wbm_cyc_o, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_valid", rsp_valid, 0);
        check("post_rdata", rsp_rdata, 0);
        check("post_err", rsp_err, 0);
        check("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_cmd_ready", cmd_ready, 1);

        // write, ack after one extra cycle
        sb.push_back({1'b0, 32'h0});
        issue(1'b1, 32'h3003_0004, 32'h000A_BCDE, 4'hF);
        run_bus(1'b1, 32'h3003_0004, 32'h000A_BCDE, 4'hF, 2, 32'hFFFF_FFFF, 2);
        take_rsp(0, 0);

        // read with three wait states
        sb.push_back({1'b0, 32'h1234_5678});
        issue(1'b0, 32'h3003_000C, 32'h0, 4'hF);
        run_bus(1'b0, 32'h3003_000C, 32'h0, 4'hF, 4, 32'h1234_5678, 4);
        take_rsp(0, 0);

        // no ack: timeout after 16 stb cycles
        sb.push_back({1'b1, 32'h0});
        issue(1'b0, 32'h3003_0010, 32'h0, 4'h3);
        run_bus(1'b0, 32'h3003_0010, 32'h0, 4'h3, 0, 32'h0, 16);
        take_rsp(0, 0);

        // response back-pressure with stray ack and stray command
        sb.push_back({1'b0, 32'hCAFE_0042});
        issue(1'b0, 32'h3003_0020, 32'h1111_2222, 4'hC);
        run_bus(1'b0, 32'h3003_0020, 32'h1111_2222, 4'hC, 1, 32'hCAFE_0042, 1);
        take_rsp(5, 1);

        // ack on the expiry edge wins
        sb.push_back({1'b0, 32'h8765_4321});
        issue(1'b0, 32'h3003_0008, 32'h0, 4'hF);
        run_bus(1'b0, 32'h3003_0008, 32'h0, 4'hF, 16, 32'h8765_4321, 16);
        take_rsp(0, 0);

        // reset in the middle of a bus cycle
        issue(1'b1, 32'h3003_0030, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        check("mid_cyc", wbm_cyc_o, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_cyc", wbm_cyc_o, 0);
        check("arst_stb", wbm_stb_o, 0);
        check("arst_adr", wbm_adr_o, 0);
        check("arst_dat", wbm_dat_o, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arel_cmd_ready", cmd_ready, 1);
        wbm_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wbm_ack_i = 1'b0;
            check("arel_rsp_valid", rsp_valid, 0);
            check("arel_cyc", wbm_cyc_o, 0);
        end

        // normal operation after reset, single-cycle ack
        sb.push_back({1'b0, 32'h0000_00FF});
        issue(1'b0, 32'h3003_0000, 32'h0, 4'h1);
        run_bus(1'b0, 32'h3003_0000, 32'h0, 4'h1, 1, 32'h0000_00FF, 1);
        take_rsp(1, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
